// File: rtl/trap_sequencer.sv
// trap_sequencer: trap/mret sequencer that owns the CSR write port while
//   writing mepc/mcause/mstatus, then redirects the PC.
//   in : clk, rst (sync, active-low), valid_E, illegal_E, ebreak_E, ecall_E,
//        mret_E, PCE, irq_ext, mstatus_q, mtvec_q, mepc_q, mie_meie,
//        csr_wr_pipe, csr_addr_pipe, csr_wd_pipe
//   out: csr_we, csr_waddr, csr_wdata, stall_front, bubble_M, flush_front,
//        pc_redirect, pc_target, trap_busy
module trap_sequencer #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] IRQ_CAUSE = 32'h8000_000B
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_E,
  input  logic            illegal_E,
  input  logic            ebreak_E,
  input  logic            ecall_E,
  input  logic            mret_E,
  input  logic [XLEN-1:0] PCE,
  input  logic            irq_ext,
  input  logic [XLEN-1:0] mstatus_q,
  input  logic [XLEN-1:0] mtvec_q,
  input  logic [XLEN-1:0] mepc_q,
  input  logic            mie_meie,
  input  logic            csr_wr_pipe,
  input  logic [11:0]     csr_addr_pipe,
  input  logic [XLEN-1:0] csr_wd_pipe,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            stall_front,
  output logic            bubble_M,
  output logic            flush_front,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target,
  output logic            trap_busy
);
  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STATUS, M_STATUS, REDIRECT} state_t;
  state_t          state;
  logic [XLEN-1:0] epc_r, cause_r, cause_n, st_trap, st_mret, base, fsm_addr_data;
  logic            irq_r, mret_r, exc, mret_t, irq_t, take, fsm_wr, fsm_we;
  logic [11:0]     fsm_addr;
  logic [XLEN-1:0] fsm_data;
  // Priority: synchronous exceptions, then mret, then the external interrupt.
  assign exc     = valid_E & (illegal_E | ebreak_E | ecall_E);
  assign mret_t  = valid_E & mret_E & ~exc;
  assign irq_t   = valid_E & irq_ext & mstatus_q[3] & mie_meie & ~exc & ~mret_t;
  assign take    = exc | mret_t | irq_t;
  assign cause_n = illegal_E ? XLEN'(2) : ebreak_E ? XLEN'(3) : ecall_E ? XLEN'(11) : IRQ_CAUSE;
  always_ff @(posedge clk)
    if (!rst) begin
      state   <= IDLE;
      epc_r   <= '0;
      cause_r <= '0;
      irq_r   <= 1'b0;
      mret_r  <= 1'b0;
    end else
      case (state)
        IDLE: if (take) begin
          epc_r   <= PCE;
          cause_r <= cause_n;
          irq_r   <= irq_t;
          mret_r  <= mret_t;
          state   <= mret_t ? M_STATUS : W_EPC;
        end
        // A pending pipeline write owns the port; hold and retry next cycle.
        W_EPC:              if (!csr_wr_pipe) state <= W_CAUSE;
        W_CAUSE:            if (!csr_wr_pipe) state <= W_STATUS;
        W_STATUS, M_STATUS: if (!csr_wr_pipe) state <= REDIRECT;
        default:            state <= IDLE;
      endcase
  always_comb begin
    st_trap    = mstatus_q;
    st_trap[7] = mstatus_q[3];
    st_trap[3] = 1'b0;
    st_mret    = mstatus_q;
    st_mret[3] = mstatus_q[7];
    st_mret[7] = 1'b1;
    fsm_addr   = state == W_EPC ? 12'h341 : state == W_CAUSE ? 12'h342 : 12'h300;
    fsm_data   = state == W_EPC ? epc_r : state == W_CAUSE ? cause_r : state == W_STATUS ? st_trap : st_mret;
    fsm_addr_data = fsm_data;
    fsm_wr     = state inside {W_EPC, W_CAUSE, W_STATUS, M_STATUS};
    fsm_we     = fsm_wr & ~csr_wr_pipe;
    csr_we     = csr_wr_pipe | fsm_we;
    csr_waddr  = fsm_we ? fsm_addr : csr_addr_pipe;
    csr_wdata  = fsm_we ? fsm_addr_data : csr_wd_pipe;
    trap_busy  = state != IDLE;
    stall_front = state == IDLE ? take : state != REDIRECT;
    bubble_M    = state == IDLE ? take : 1'b1;
    pc_redirect = state == REDIRECT;
    flush_front = state == REDIRECT;
    base        = {mtvec_q[XLEN-1:2], 2'b00};
    // Shifting the full cause drops bits 31:30, which is the vector offset mod 2^XLEN.
    pc_target   = state != REDIRECT ? '0 : mret_r ? mepc_q :
                  (irq_r && mtvec_q[1:0] == 2'b01) ? base + (cause_r << 2) : base;
  end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed + randomized check of trap_sequencer against a write-list model.
module tb_trap_sequencer;
  logic        clk = 1'b0, rst = 1'b0;
  logic        valid_E = 0, illegal_E = 0, ebreak_E = 0, ecall_E = 0, mret_E = 0, irq_ext = 0, mie_meie = 0;
  logic [31:0] PCE = 0, mstatus_q = 0, mtvec_q = 0, mepc_q = 0, csr_wd_pipe = 0;
  logic        csr_wr_pipe = 0;
  logic [11:0] csr_addr_pipe = 0;
  logic        csr_we, stall_front, bubble_M, flush_front, pc_redirect, trap_busy;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, pc_target;
  int          n_chk = 0, n_fail = 0;
  trap_sequencer dut (
    .clk(clk), .rst(rst), .valid_E(valid_E), .illegal_E(illegal_E), .ebreak_E(ebreak_E),
    .ecall_E(ecall_E), .mret_E(mret_E), .PCE(PCE), .irq_ext(irq_ext), .mstatus_q(mstatus_q),
    .mtvec_q(mtvec_q), .mepc_q(mepc_q), .mie_meie(mie_meie), .csr_wr_pipe(csr_wr_pipe),
    .csr_addr_pipe(csr_addr_pipe), .csr_wd_pipe(csr_wd_pipe), .csr_we(csr_we),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .stall_front(stall_front),
    .bubble_M(bubble_M), .flush_front(flush_front), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .trap_busy(trap_busy));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic clear_dec();
    {valid_E, illegal_E, ebreak_E, ecall_E, mret_E, irq_ext} = '0;
  endtask
  // Offers one instruction in cycle T, then checks every cycle until the redirect.
  // pm[k] asserts the pipeline write in cycle T+1+k.
  task automatic run_seq(input logic ill, ebr, ecl, mr, irq, vld,
                         input logic [31:0] pc, tv, st, ep, input logic meie, input logic [15:0] pm);
    logic [11:0] qa[$];
    logic [31:0] qd[$];
    logic        exc, mr_ok, irq_ok, acc, done, p;
    logic [31:0] cause, base, tgt, wd;
    exc    = vld & (ill | ebr | ecl);
    mr_ok  = vld & mr & !exc;
    irq_ok = vld & irq & st[3] & meie & !exc & !mr_ok;
    acc    = exc | mr_ok | irq_ok;
    cause  = ill ? 32'd2 : ebr ? 32'd3 : ecl ? 32'd11 : 32'h8000_000B;
    base   = tv & ~32'h3;
    tgt    = (irq_ok && tv[1:0] == 2'b01) ? base + cause * 4 : base;
    if (exc | irq_ok) begin
      qa = '{12'h341, 12'h342, 12'h300};
      qd = '{pc, cause, (st & ~32'h88) | (32'(st[3]) << 7)};
    end else if (mr_ok) begin
      qa = '{12'h300};
      qd = '{(st & ~32'h88) | (32'(st[7]) << 3) | 32'h80};
      tgt = ep;
    end
    @(negedge clk);
    {illegal_E, ebreak_E, ecall_E, mret_E, irq_ext, valid_E} = {ill, ebr, ecl, mr, irq, vld};
    {PCE, mtvec_q, mstatus_q, mepc_q, mie_meie} = {pc, tv, st, ep, meie};
    csr_wr_pipe = 0;
    #1;
    chk("accept_stall", 32'(stall_front), 32'(acc));
    chk("accept_bubble", 32'(bubble_M), 32'(acc));
    chk("accept_busy", 32'(trap_busy), 0);
    chk("accept_we", 32'(csr_we), 0);
    done = !acc;
    for (int k = 0; k < 24 && !done; k++) begin
      @(negedge clk);
      clear_dec();
      p = k < 16 ? pm[k] : 1'b0;
      wd = $urandom;
      csr_wr_pipe = p; csr_addr_pipe = 12'h340; csr_wd_pipe = wd;
      #1;
      if (qa.size() > 0) begin
        chk("seq_busy", 32'(trap_busy), 1);
        chk("seq_stall", 32'(stall_front), 1);
        chk("seq_redirect", 32'(pc_redirect), 0);
        chk("seq_we", 32'(csr_we), 1);
        if (p) begin
          chk("pipe_addr", 32'(csr_waddr), 32'h340);
          chk("pipe_data", csr_wdata, wd);
        end else begin
          chk("fsm_addr", 32'(csr_waddr), 32'(qa.pop_front()));
          chk("fsm_data", csr_wdata, qd.pop_front());
        end
      end else begin
        chk("redir", 32'(pc_redirect), 1);
        chk("redir_flush", 32'(flush_front), 1);
        chk("redir_stall", 32'(stall_front), 0);
        chk("redir_bubble", 32'(bubble_M), 1);
        chk("redir_target", pc_target, tgt);
        done = 1;
      end
    end
    chk("seq_complete", 32'(done), 1);
    @(negedge clk);
    clear_dec();
    csr_wr_pipe = 0;
    #1;
    chk("after_busy", 32'(trap_busy), 0);
    chk("after_redirect", 32'(pc_redirect), 0);
  endtask
  initial begin
    // Reset state, with the pipeline pass-through still live.
    csr_wr_pipe = 1; csr_addr_pipe = 12'h305; csr_wd_pipe = 32'hABCD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(trap_busy), 0);
    chk("rst_stall", 32'(stall_front), 0);
    chk("rst_redirect", 32'(pc_redirect), 0);
    chk("rst_target", pc_target, 0);
    chk("rst_we_pass", 32'(csr_we), 1);
    chk("rst_addr_pass", 32'(csr_waddr), 32'h305);
    chk("rst_data_pass", csr_wdata, 32'hABCD);
    @(negedge clk);
    rst = 1; csr_wr_pipe = 0;
    #1;
    chk("idle_we", 32'(csr_we), 0);
    // Directed cases.
    run_seq(0, 0, 1, 0, 0, 1, 32'h100, 32'h200, 32'h8, 0, 0, 16'h0);
    run_seq(1, 0, 1, 0, 0, 1, 32'h180, 32'h200, 32'h8, 0, 0, 16'h0);
    run_seq(0, 0, 0, 1, 0, 1, 32'h0, 32'h200, 32'h80, 32'h104, 0, 16'h0);
    run_seq(0, 0, 0, 0, 1, 1, 32'h300, 32'h201, 32'h8, 0, 1, 16'h0);
    run_seq(0, 0, 0, 0, 1, 1, 32'h300, 32'h201, 32'h0, 0, 1, 16'h0);
    run_seq(0, 0, 1, 0, 0, 0, 32'h100, 32'h200, 32'h8, 0, 0, 16'h0);
    run_seq(0, 0, 1, 0, 0, 1, 32'h100, 32'h200, 32'h8, 0, 0, 16'h3);
    // Reset in the middle of a trap: ecall at T, rst low during T+2.
    @(negedge clk);
    {valid_E, ecall_E, PCE, mtvec_q, mstatus_q} = {1'b1, 1'b1, 32'h400, 32'h200, 32'h8};
    @(negedge clk);
    clear_dec();
    #1;
    chk("mid_epc_we", 32'(csr_we), 1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    chk("mid_rst_busy", 32'(trap_busy), 0);
    chk("mid_rst_stall", 32'(stall_front), 0);
    chk("mid_rst_redirect", 32'(pc_redirect), 0);
    chk("mid_rst_we", 32'(csr_we), 0);
    rst = 1;
    run_seq(0, 0, 1, 0, 0, 1, 32'h500, 32'h600, 32'h88, 0, 0, 16'h0);
    // Randomized instructions and pipeline contention.
    for (int i = 0; i < 60; i++) begin
      logic [5:0] b;
      b = 6'($urandom);
      run_seq(b[0] & b[1], b[2] & b[1], b[3] & b[0], b[4], b[5] | b[2], ($urandom_range(0, 7) != 0),
              $urandom, $urandom, $urandom, $urandom, 1'($urandom), 16'($urandom & $urandom & $urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
